// File: rtl/nx_mem_typePKG.sv
// Shared types for the indirect-access memory arbiter: granted-port encoding
// and the default software starvation bound.
package nx_mem_typePKG;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SW   = 2'd1,
    HW   = 2'd2
  } arb_req_e;

  localparam int unsigned STARVE_LIMIT_DEF = 16;

endpackage

// File: rtl/nx_ia_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module nx_ia_sat_counter #(
  parameter int unsigned   W   = 5,
  parameter logic [W-1:0]  MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/nx_ia_mem_arb.sv
// Arbitrates one single-port RAM between the indirect-access controller (software)
// and the datapath (hardware). Optional stall statistics under NX_IA_MEM_ARB_STATS_EN.
module nx_ia_mem_arb
  import nx_mem_typePKG::*;
#(
  parameter int unsigned N_ADDR_BITS  = 9,
  parameter int unsigned N_DATA_BITS  = 96,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sw_cs,
  input  logic                   sw_we,
  input  logic [N_ADDR_BITS-1:0] sw_add,
  input  logic [N_DATA_BITS-1:0] sw_wdat,
  input  logic                   yield,
  input  logic                   ia_reset,
  output logic                   grant,
  output logic [N_DATA_BITS-1:0] sw_rdat,
  input  logic                   hw_req,
  input  logic                   hw_we,
  input  logic [N_ADDR_BITS-1:0] hw_add,
  input  logic [N_DATA_BITS-1:0] hw_wdat,
  output logic                   hw_gnt,
  output logic                   hw_rvld,
  output logic [N_DATA_BITS-1:0] hw_rdat,
  output logic                   mem_cs,
  output logic                   mem_we,
  output logic [N_ADDR_BITS-1:0] mem_add,
  output logic [N_DATA_BITS-1:0] mem_wdat,
  input  logic [N_DATA_BITS-1:0] mem_rdat
`ifdef NX_IA_MEM_ARB_STATS_EN
  ,
  output logic [15:0]            sw_stall_cnt
`endif
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0]    w_starve_cnt;
  logic                   w_starved;
  logic                   w_sw_stall;
  arb_req_e               w_arb;
  logic                   r_hw_rvld;
  logic                   r_sw_rd_pend;
  logic [N_DATA_BITS-1:0] r_sw_hold;

  // Software wins outright when the datapath is quiet, yields, is swept, or has starved it
  assign w_starved  = (w_starve_cnt == STARVE_W'(STARVE_LIMIT));
  assign grant      = sw_cs & (~hw_req | yield | ia_reset | w_starved);
  assign hw_gnt     = hw_req & ~grant & ~ia_reset;
  assign w_sw_stall = sw_cs & ~grant;

  always_comb begin
    w_arb = IDLE;
    if (grant) begin
      w_arb = SW;
    end else if (hw_gnt) begin
      w_arb = HW;
    end
  end

  // Idle cycles park the RAM address/data on the software values
  always_comb begin
    mem_cs   = 1'b0;
    mem_we   = 1'b0;
    mem_add  = sw_add;
    mem_wdat = sw_wdat;
    case (w_arb)
      SW: begin
        mem_cs = 1'b1;
        mem_we = sw_we;
      end
      HW: begin
        mem_cs   = 1'b1;
        mem_we   = hw_we;
        mem_add  = hw_add;
        mem_wdat = hw_wdat;
      end
      default: ;
    endcase
  end

  nx_ia_sat_counter #(
    .W   (STARVE_W),
    .MAX (STARVE_W'(STARVE_LIMIT))
  ) u_starve_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (grant | ~sw_cs),
    .i_inc (w_sw_stall),
    .o_cnt (w_starve_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hw_rvld    <= 1'b0;
      r_sw_rd_pend <= 1'b0;
      r_sw_hold    <= '0;
    end else begin
      r_hw_rvld    <= hw_gnt & ~hw_we;
      r_sw_rd_pend <= grant & ~sw_we;
      if (r_sw_rd_pend) begin
        r_sw_hold <= mem_rdat;
      end
    end
  end

  assign hw_rvld = r_hw_rvld;
  assign hw_rdat = mem_rdat;
  // Read data flows straight through in its return cycle, then comes from the hold register
  assign sw_rdat = r_sw_rd_pend ? mem_rdat : r_sw_hold;

`ifdef NX_IA_MEM_ARB_STATS_EN
  nx_ia_sat_counter #(
    .W   (16),
    .MAX (16'hFFFF)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (1'b0),
    .i_inc (w_sw_stall),
    .o_cnt (sw_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_nx_ia_mem_arb.sv
// Directed self-checking bench for nx_ia_mem_arb with a behavioural synchronous RAM.
// Stall-counter checks are compiled in with NX_IA_MEM_ARB_STATS_EN.
module tb_nx_ia_mem_arb;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 96;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sw_cs, sw_we, yield, ia_reset;
  logic [AW-1:0] sw_add;
  logic [DW-1:0] sw_wdat;
  logic          grant;
  logic [DW-1:0] sw_rdat;
  logic          hw_req, hw_we;
  logic [AW-1:0] hw_add;
  logic [DW-1:0] hw_wdat;
  logic          hw_gnt, hw_rvld;
  logic [DW-1:0] hw_rdat;
  logic          mem_cs, mem_we;
  logic [AW-1:0] mem_add;
  logic [DW-1:0] mem_wdat;
  logic [DW-1:0] mem_rdat;
`ifdef NX_IA_MEM_ARB_STATS_EN
  logic [15:0]   sw_stall_cnt;
`endif

  logic [DW-1:0] ram [0:(1<<AW)-1];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nx_ia_mem_arb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_cs    (sw_cs),
    .sw_we    (sw_we),
    .sw_add   (sw_add),
    .sw_wdat  (sw_wdat),
    .yield    (yield),
    .ia_reset (ia_reset),
    .grant    (grant),
    .sw_rdat  (sw_rdat),
    .hw_req   (hw_req),
    .hw_we    (hw_we),
    .hw_add   (hw_add),
    .hw_wdat  (hw_wdat),
    .hw_gnt   (hw_gnt),
    .hw_rvld  (hw_rvld),
    .hw_rdat  (hw_rdat),
    .mem_cs   (mem_cs),
    .mem_we   (mem_we),
    .mem_add  (mem_add),
    .mem_wdat (mem_wdat),
    .mem_rdat (mem_rdat)
`ifdef NX_IA_MEM_ARB_STATS_EN
    ,
    .sw_stall_cnt (sw_stall_cnt)
`endif
  );

  // Single-port synchronous RAM, one-cycle read latency
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) ram[mem_add] <= mem_wdat;
      else        mem_rdat     <= ram[mem_add];
    end
  end

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    sw_cs = 1'b0; sw_we = 1'b0; hw_req = 1'b0; hw_we = 1'b0;
    yield = 1'b0; ia_reset = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  int n_grant, n_hwg;
  logic [DW-1:0] sweep_exp;

  initial begin
    rst_n = 1'b0;
    idle_in();
    sw_add = '0; sw_wdat = '0; hw_add = '0; hw_wdat = '0;
    repeat (2) step();
    #1;
    check_eq("rst_hw_rvld", DW'(hw_rvld), DW'(0));
    check_eq("rst_sw_rdat", sw_rdat, DW'(0));
    check_eq("rst_mem_cs",  DW'(mem_cs), DW'(0));
    rst_n = 1'b1;

    // Software write RAM[5] = A5
    step();
    sw_cs = 1'b1; sw_we = 1'b1; sw_add = 9'h005; sw_wdat = 96'hA5;
    #1;
    check_eq("sww_grant",  DW'(grant), DW'(1));
    check_eq("sww_mem_we", DW'(mem_we), DW'(1));
    check_eq("sww_wdat",   mem_wdat, 96'hA5);

    // Hardware write RAM[7]
    step();
    idle_in();
    hw_req = 1'b1; hw_we = 1'b1; hw_add = 9'h007; hw_wdat = 96'h1234_5678;
    #1;
    check_eq("hww_hw_gnt", DW'(hw_gnt), DW'(1));
    check_eq("hww_grant",  DW'(grant), DW'(0));
    check_eq("hww_mem_add", DW'(mem_add), DW'(9'h007));

    // Software read of RAM[5]: grant now, data next cycle, held afterwards
    step();
    idle_in();
    sw_cs = 1'b1; sw_we = 1'b0; sw_add = 9'h005;
    #1;
    check_eq("swr_grant",  DW'(grant), DW'(1));
    check_eq("swr_mem_we", DW'(mem_we), DW'(0));
    step();
    idle_in();
    #1;
    check_eq("swr_rdat_pass", sw_rdat, 96'hA5);
    step();
    #1;
    check_eq("swr_rdat_hold", sw_rdat, 96'hA5);

    // Hardware read of RAM[7]; software hold must not follow the new RAM data
    step();
    hw_req = 1'b1; hw_we = 1'b0; hw_add = 9'h007;
    #1;
    check_eq("hwr_hw_gnt", DW'(hw_gnt), DW'(1));
    step();
    idle_in();
    #1;
    check_eq("hwr_rvld",    DW'(hw_rvld), DW'(1));
    check_eq("hwr_rdat",    hw_rdat, 96'h1234_5678);
    check_eq("hwr_sw_hold", sw_rdat, 96'hA5);
    step();
    #1;
    check_eq("hwr_rvld_drop", DW'(hw_rvld), DW'(0));

    // Nothing granted: RAM port parks on software address/data
    sw_add = 9'h033; sw_wdat = 96'hDEAD; hw_add = 9'h044; hw_wdat = 96'hBEEF;
    #1;
    check_eq("idle_mem_add",  DW'(mem_add), DW'(9'h033));
    check_eq("idle_mem_wdat", mem_wdat, 96'hDEAD);
    check_eq("idle_mem_we",   DW'(mem_we), DW'(0));

    // Contention: 16 hardware grants, software forced on the 17th, counter restarts
    step();
    sw_cs = 1'b1; sw_we = 1'b1; sw_add = 9'h020; sw_wdat = 96'h20;
    hw_req = 1'b1; hw_we = 1'b1; hw_add = 9'h021; hw_wdat = 96'h21;
    for (int c = 1; c <= 18; c++) begin
      #1;
      if (c == 17) begin
        check_eq($sformatf("cont%0d_grant", c), DW'(grant), DW'(1));
        check_eq($sformatf("cont%0d_hw_gnt", c), DW'(hw_gnt), DW'(0));
        check_eq("cont_mem_add", DW'(mem_add), DW'(9'h020));
      end else begin
        check_eq($sformatf("cont%0d_hw_gnt", c), DW'(hw_gnt), DW'(1));
        check_eq($sformatf("cont%0d_grant", c), DW'(grant), DW'(0));
      end
      step();
    end

    // Yield hands the port to software immediately
    idle_in();
    step();
    sw_cs = 1'b1; sw_we = 1'b1; hw_req = 1'b1; yield = 1'b1;
    #1;
    check_eq("yield_grant",  DW'(grant), DW'(1));
    check_eq("yield_hw_gnt", DW'(hw_gnt), DW'(0));

    // Init sweep: 512 software writes, datapath locked out
    step();
    idle_in();
    n_grant = 0; n_hwg = 0;
    for (int i = 0; i < 512; i++) begin
      step();
      ia_reset = 1'b1; hw_req = 1'b1; hw_we = 1'b0; sw_cs = 1'b1; sw_we = 1'b1;
      sw_add = AW'(i); sw_wdat = {32'hC0DE_0000, 55'd0, AW'(i)};
      #1;
      n_grant += int'(grant & mem_we);
      n_hwg   += int'(hw_gnt);
    end
    check_eq("sweep_grants", DW'(n_grant), DW'(512));
    check_eq("sweep_hw_gnt", DW'(n_hwg), DW'(0));

    // Read back the last swept word through the software port
    step();
    idle_in();
    sw_cs = 1'b1; sw_we = 1'b0; sw_add = 9'h1FF;
    step();
    idle_in();
    sweep_exp = {32'hC0DE_0000, 55'd0, 9'h1FF};
    #1;
    check_eq("sweep_readback", sw_rdat, sweep_exp);

    // Reset lands the cycle after a hardware read grant
    step();
    hw_req = 1'b1; hw_we = 1'b0; hw_add = 9'h007;
    #1;
    check_eq("rmr_hw_gnt", DW'(hw_gnt), DW'(1));
    step();
    idle_in();
    rst_n = 1'b0;
    #1;
    check_eq("rmr_rvld_in_rst", DW'(hw_rvld), DW'(0));
    step();
    rst_n = 1'b1;
    step();
    #1;
    check_eq("rmr_rvld_after", DW'(hw_rvld), DW'(0));
    check_eq("rmr_sw_rdat",    sw_rdat, DW'(0));

`ifdef NX_IA_MEM_ARB_STATS_EN
    // Five stalled software cycles, then saturation under a long forced stall
    check_eq("stat_rst", DW'(sw_stall_cnt), DW'(0));
    step();
    sw_cs = 1'b1; sw_we = 1'b1; hw_req = 1'b1; hw_we = 1'b1;
    repeat (5) step();
    idle_in();
    #1;
    check_eq("stat_5", DW'(sw_stall_cnt), DW'(5));
    step();
    sw_cs = 1'b1; sw_we = 1'b1; hw_req = 1'b1; hw_we = 1'b1;
    repeat (75000) step();
    idle_in();
    #1;
    check_eq("stat_sat", DW'(sw_stall_cnt), DW'(16'hFFFF));
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
